// File: rtl/qspi_flash_arbiter.sv
// Two-port round-robin arbiter that runs QSPI flash reads through the controller's register bus.
// Optional build macro QSPI_ARB_TIMEOUT_EN adds a poll-cycle timeout that reports through err_o.
module qspi_flash_arbiter #(
    parameter logic [31:0] CCR_READ    = 32'h0000_00EB,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [2:0]  len0_i,
    input  logic [2:0]  len1_i,
    output logic [1:0]  gnt_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rvalid_o,
    output logic [1:0]  done_o,
    output logic [1:0]  err_o,
    output logic        m_write_o,
    output logic [3:0]  m_be_o,
    output logic [5:0]  m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic [31:0] m_rdata_i
);

    typedef enum logic [2:0] {IDLE, WR_ADR, WR_CCR, POLL, RD_DR, CLR} state_t;

    state_t     state;
    logic [2:0] len_q;
    logic [2:0] cnt;
    logic       owner;
    logic       last;
    logic       pick;
    logic [1:0] owner_oh;

`ifdef QSPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] tcnt;
    logic [1:0]    err_q;
    assign err_o = err_q;
`else
    assign err_o = 2'b00;
`endif

    assign owner_oh = owner ? 2'b10 : 2'b01;

    // Read data is combinational from the registered DR address, so it is forwarded in the same cycle.
    assign rdata_o = (|rvalid_o) ? m_rdata_i : 32'h0;

    always_comb begin
        pick = 1'b0;
        if (req_i == 2'b11) begin
            pick = ~last;
        end else if (req_i[1]) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            cnt       <= 3'd0;
            gnt_o     <= 2'b00;
            rvalid_o  <= 2'b00;
            done_o    <= 2'b00;
            m_write_o <= 1'b0;
            m_be_o    <= 4'h0;
            m_addr_o  <= 6'h00;
            m_wdata_o <= 32'h0;
`ifdef QSPI_ARB_TIMEOUT_EN
            err_q     <= 2'b00;
            tcnt      <= '0;
`endif
        end else begin
            gnt_o    <= 2'b00;
            rvalid_o <= 2'b00;
            done_o   <= 2'b00;
`ifdef QSPI_ARB_TIMEOUT_EN
            err_q    <= 2'b00;
`endif
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        owner     <= pick;
                        last      <= pick;
                        len_q     <= pick ? len1_i : len0_i;
                        gnt_o     <= pick ? 2'b10 : 2'b01;
                        m_write_o <= 1'b1;
                        m_be_o    <= 4'hF;
                        m_addr_o  <= 6'h04;
                        m_wdata_o <= pick ? addr1_i : addr0_i;
                        state     <= WR_ADR;
                    end
                end
                WR_ADR: begin
                    m_addr_o  <= 6'h00;
                    m_wdata_o <= {CCR_READ[31:28], len_q, CCR_READ[24:0]};
                    state     <= WR_CCR;
                end
                WR_CCR: begin
                    m_write_o <= 1'b0;
                    m_be_o    <= 4'h1;
                    m_addr_o  <= 6'h28;
                    m_wdata_o <= 32'h0;
`ifdef QSPI_ARB_TIMEOUT_EN
                    tcnt      <= '0;
`endif
                    state     <= POLL;
                end
                POLL: begin
                    if (m_rdata_i[1]) begin
                        m_be_o   <= 4'hF;
                        m_addr_o <= 6'h08;
                        cnt      <= 3'd0;
                        rvalid_o <= owner_oh;
                        state    <= RD_DR;
                    end
`ifdef QSPI_ARB_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        m_write_o <= 1'b1;
                        m_be_o    <= 4'h8;
                        m_addr_o  <= 6'h03;
                        m_wdata_o <= 32'h8000_0000;
                        done_o    <= owner_oh;
                        err_q     <= owner_oh;
                        state     <= CLR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                RD_DR: begin
                    if (cnt == len_q) begin
                        m_write_o <= 1'b1;
                        m_be_o    <= 4'h8;
                        m_addr_o  <= 6'h03;
                        m_wdata_o <= 32'h8000_0000;
                        done_o    <= owner_oh;
                        state     <= CLR;
                    end else begin
                        cnt      <= cnt + 3'd1;
                        m_addr_o <= 6'h08 + {1'b0, cnt + 3'd1, 2'b00};
                        rvalid_o <= owner_oh;
                    end
                end
                CLR: begin
                    m_write_o <= 1'b0;
                    m_be_o    <= 4'h0;
                    m_addr_o  <= 6'h00;
                    m_wdata_o <= 32'h0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// Randomized transaction-level bench for qspi_flash_arbiter with a behavioural QSPI register model.
module tb_qspi_flash_arbiter;

    localparam logic [31:0] CCR = 32'h0000_00EB;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] addr0, addr1;
    logic [2:0]  len0, len1;
    logic [1:0]  gnt, rvalid, done, err;
    logic [31:0] rdata;
    logic        m_write;
    logic [3:0]  m_be;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    qspi_flash_arbiter dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .addr0_i(addr0), .addr1_i(addr1), .len0_i(len0), .len1_i(len1),
        .gnt_o(gnt), .rdata_o(rdata), .rvalid_o(rvalid), .done_o(done), .err_o(err),
        .m_write_o(m_write), .m_be_o(m_be), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_rdata_i(m_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash controller model: STA[1] rises sta_delay cycles after the CCR write, cleared by the CLR write.
    logic [31:0] dr [8];
    logic        armed;
    int          ccr_cyc;
    int          sta_delay;
    logic        sta_done;

    always @(posedge clk) begin
        if (rst) armed <= 1'b0;
        else if (m_write && m_addr == 6'h00) begin
            armed   <= 1'b1;
            ccr_cyc <= cyc;
        end else if (m_write && m_addr == 6'h03 && m_be[3] && m_wdata[31]) armed <= 1'b0;
    end

    assign sta_done = armed && (cyc >= ccr_cyc + sta_delay);

    always_comb begin
        m_rdata = 32'h0;
        if (m_addr == 6'h28) m_rdata = {30'h0, sta_done, 1'b0};
        else if (m_addr >= 6'h08 && m_addr <= 6'h24 && m_addr[1:0] == 2'b00)
            m_rdata = dr[(int'(m_addr) - 8) / 4];
    end

    typedef struct {
        logic [5:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
        int          t;
    } ev_t;

    ev_t gntq[$], wrq[$], rdq[$], doneq[$];

    always @(negedge clk) begin
        if (gnt != 2'b00)   gntq.push_back('{6'h0, 4'h0, {30'h0, gnt}, cyc});
        if (m_write)        wrq.push_back('{m_addr, m_be, m_wdata, cyc});
        if (rvalid != 2'b00) rdq.push_back('{m_addr, {2'b00, rvalid}, rdata, cyc});
        if (done != 2'b00 || err != 2'b00) doneq.push_back('{6'h0, 4'h0, {28'h0, err, done}, cyc});
    end

    int n_vec = 0;
    int n_err = 0;
    int rr_last = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        gntq.delete(); wrq.delete(); rdq.delete(); doneq.delete();
    endtask

    task automatic fill_dr();
        for (int k = 0; k < 8; k++) dr[k] = $urandom;
    endtask

    task automatic wait_q(input int which, input int n, input int budget);
        int sz;
        for (int c = 0; c < budget; c++) begin
            sz = (which == 0) ? gntq.size() : (which == 1) ? doneq.size() : rdq.size();
            if (sz >= n) break;
            @(negedge clk); #1;
        end
        sz = (which == 0) ? gntq.size() : (which == 1) ? doneq.size() : rdq.size();
        check(which == 0 ? "wait_gnt" : which == 1 ? "wait_done" : "wait_rd", 32'(sz >= n), 32'd1);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_gnt"},    {30'h0, gnt}, 0);
        check({pfx, "_rvalid"}, {30'h0, rvalid}, 0);
        check({pfx, "_done"},   {30'h0, done}, 0);
        check({pfx, "_err"},    {30'h0, err}, 0);
        check({pfx, "_mwrite"}, {31'h0, m_write}, 0);
        check({pfx, "_mbe"},    {28'h0, m_be}, 0);
        check({pfx, "_maddr"},  {26'h0, m_addr}, 0);
        check({pfx, "_mwdata"}, m_wdata, 0);
        check({pfx, "_rdata"},  rdata, 0);
    endtask

    // Checks the i-th transaction in the logs; its words start at rdq[rb].
    task automatic check_txn(input int i, input int p, input logic [31:0] a, input logic [2:0] l,
                             input int dly, input bit exp_err, input int rb);
        logic [31:0] oh;
        int          lat;
        int          nw;
        oh  = 32'(1) << p;
        lat = 2 + ((dly < 1) ? 1 : dly);
        nw  = exp_err ? 0 : int'(l) + 1;
        if (gntq.size() <= i || wrq.size() < 3 * i + 3 || doneq.size() <= i || rdq.size() < rb + nw) begin
            check("log_complete", 0, 1);
            return;
        end
        check("gnt", gntq[i].d, oh);
        check("wr_adr_a",  {26'h0, wrq[3*i].a}, 32'h04);
        check("wr_adr_be", {28'h0, wrq[3*i].be}, 32'hF);
        check("wr_adr_d",  wrq[3*i].d, a);
        check("wr_ccr_a",  {26'h0, wrq[3*i+1].a}, 32'h00);
        check("wr_ccr_d",  wrq[3*i+1].d, (CCR & ~(32'h7 << 25)) | (32'(l) << 25));
        check("wr_clr_a",  {26'h0, wrq[3*i+2].a}, 32'h03);
        check("wr_clr_be", {28'h0, wrq[3*i+2].be}, 32'h8);
        check("wr_clr_d31", {31'h0, wrq[3*i+2].d[31]}, 32'h1);
        for (int k = 0; k < nw; k++) begin
            check("rd_owner", {28'h0, rdq[rb+k].be}, oh);
            check("rd_addr",  {26'h0, rdq[rb+k].a}, 32'h08 + 32'(4 * k));
            check("rd_data",  rdq[rb+k].d, dr[k]);
            check("rd_time",  32'(rdq[rb+k].t - gntq[i].t), 32'(lat + k));
        end
        check("done", doneq[i].d, exp_err ? (oh | (oh << 2)) : oh);
        if (!exp_err) check("done_time", 32'(doneq[i].t - gntq[i].t), 32'(lat + nw));
    endtask

    task automatic txn1(input int p, input logic [31:0] a, input logic [2:0] l, input int dly);
        clear_q();
        sta_delay = dly;
        if (p == 0) begin addr0 = a; len0 = l; end
        else begin addr1 = a; len1 = l; end
        req = 2'b00;
        req[p] = 1'b1;
        wait_q(0, 1, 20);
        addr0 = $urandom; addr1 = $urandom;
        len0 = 3'($urandom); len1 = 3'($urandom);
        wait_q(1, 1, 200);
        req = 2'b00;
        check("n_words", rdq.size(), int'(l) + 1);
        check_txn(0, p, a, l, dly, 1'b0, 0);
        rr_last = p;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic txn2(input logic [31:0] a0, input logic [2:0] l0, input logic [31:0] a1,
                        input logic [2:0] l1, input int dly);
        int first, second;
        clear_q();
        sta_delay = dly;
        addr0 = a0; len0 = l0; addr1 = a1; len1 = l1;
        first  = (rr_last == 0) ? 1 : 0;
        second = 1 - first;
        req = 2'b11;
        wait_q(1, 1, 200);
        req[first] = 1'b0;
        wait_q(1, 2, 200);
        req = 2'b00;
        check("n_words2", rdq.size(), int'(l0) + int'(l1) + 2);
        check_txn(0, first,  first  ? a1 : a0, first  ? l1 : l0, dly, 1'b0, 0);
        check_txn(1, second, second ? a1 : a0, second ? l1 : l0, dly, 1'b0,
                  int'(first ? l1 : l0) + 1);
        rr_last = second;
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; addr0 = 0; addr1 = 0; len0 = 0; len1 = 0;
        sta_delay = 1;
        fill_dr();
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk); #1;
        check_outputs_zero("idle");

        // Both ports requesting straight out of reset: port 0 first.
        txn2(32'h0000_2000, 3'd1, 32'h0000_3000, 3'd1, 2);

        // Single word, STA rising two cycles after the CCR write.
        fill_dr();
        txn1(0, 32'h0000_0100, 3'd0, 2);

        // Maximum burst on the data port.
        for (int k = 0; k < 8; k++) dr[k] = 32'hA0 + 32'(k);
        txn1(1, 32'h0040_0000, 3'd7, 1);

        for (int n = 0; n < 16; n++) begin
            fill_dr();
            txn1(int'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
                 int'($urandom_range(1, 6)));
        end
        for (int n = 0; n < 4; n++) begin
            fill_dr();
            txn2($urandom, 3'($urandom_range(0, 7)), $urandom, 3'($urandom_range(0, 7)),
                 int'($urandom_range(1, 5)));
        end

        // Reset in the middle of a burst, after word 2.
        clear_q();
        fill_dr();
        sta_delay = 1;
        addr1 = 32'h1234_5678; len1 = 3'd7;
        req = 2'b10;
        wait_q(2, 3, 60);
        rst = 1'b1;
        @(negedge clk); #1;
        check_outputs_zero("midrst");
        rst = 1'b0;
        req = 2'b00;
        repeat (20) @(negedge clk);
        #1;
        check("midrst_no_done", doneq.size(), 0);
        rr_last = 1;
        fill_dr();
        txn2(32'h0000_0400, 3'd2, 32'h0000_0800, 3'd3, 3);

`ifdef QSPI_ARB_TIMEOUT_EN
        clear_q();
        sta_delay = 1_000_000;
        addr0 = 32'h0000_0F00; len0 = 3'd3;
        req = 2'b01;
        wait_q(1, 1, 1200);
        req = 2'b00;
        check("to_no_rvalid", rdq.size(), 0);
        check_txn(0, 0, 32'h0000_0F00, 3'd3, 1, 1'b1, 0);
        if (doneq.size() > 0 && gntq.size() > 0)
            check("to_time", 32'(doneq[0].t - gntq[0].t), 32'd1026);
        rr_last = 0;
        repeat (2) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qspi_flash_arbiter.md
QSPI_FLASH_ARBITER -- requirements
Module: qspi_flash_arbiter

Interface
REQ-001 SHALL have parameter CCR_READ, default 32'h0000_00EB, CCR word written to start a flash read.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, poll-cycle limit per transfer.
REQ-003 SHALL have port clk_i  input  1  the block's only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports req_i  input  2, one bit per requester (0 = fetch, 1 = data): transfer request.
REQ-006 SHALL have ports addr0_i and addr1_i  input  32  flash byte address per requester.
REQ-007 SHALL have ports len0_i and len1_i  input  3  word count minus one, 0..7.
REQ-008 SHALL have port gnt_o  output  2  one-hot grant, 1-cycle pulse.
REQ-009 SHALL have port rdata_o  output  32  read word to the granted requester.
REQ-010 SHALL have port rvalid_o  output  2  per-requester word-valid strobe.
REQ-011 SHALL have port done_o  output  2  per-requester transfer-complete pulse.
REQ-012 SHALL have port err_o  output  2  per-requester timeout pulse, coincident with done_o.
REQ-013 SHALL have ports m_write_o (1), m_be_o (4), m_addr_o (6), m_wdata_o (32)  output: QSPI register bus.
REQ-014 SHALL have port m_rdata_i  input  32  QSPI register read data, combinational from m_addr_o.

Function
REQ-015 SHALL implement states IDLE, WR_ADR, WR_CCR, POLL, RD_DR, CLR.
REQ-016 In IDLE with any req_i set, SHALL latch address/length of the chosen requester, pulse gnt_o, go to WR_ADR.
REQ-017 Arbitration SHALL be round-robin: both requesting -> grant the port not granted last; single request -> grant it.
REQ-018 WR_ADR SHALL drive m_write_o=1, m_be_o=4'hF, m_addr_o=6'h04, m_wdata_o=latched address for one cycle.
REQ-019 WR_CCR SHALL write CCR_READ with bits [27:25] replaced by latched length, at m_addr_o=6'h00, for one cycle.
REQ-020 POLL SHALL drive m_addr_o=6'h28, m_be_o=4'h1, m_write_o=0; advance to RD_DR when m_rdata_i[1]=1.
REQ-021 RD_DR SHALL read words k=0..len at m_addr_o=6'h08+4k, one per cycle, presenting m_rdata_i on rdata_o with rvalid_o[owner]=1 the same cycle.
REQ-022 CLR SHALL write m_addr_o=6'h03, m_be_o=4'h8, m_wdata_o[31]=1 (clears done flag), pulse done_o[owner], return to IDLE.
REQ-023 m_write_o SHALL be 0 in IDLE, POLL, RD_DR; m_be_o/m_addr_o/m_wdata_o SHALL be 0 in IDLE.
REQ-024 Latency from gnt_o to first rvalid_o SHALL be 3 + poll cycles until done observed; burst of len+1 words back-to-back.
REQ-025 Requests arriving or deasserting during a transfer SHALL be ignored; no preemption; requester holds req_i until done_o.
REQ-026 Latched address/length SHALL not change after grant regardless of addr*_i/len*_i activity.
REQ-027 Word counter SHALL be 3 bits; len=7 reads exactly 8 words, no wrap into 6'h28.

Reset
REQ-028 rst_i SHALL return state to IDLE on the next edge, including mid-transfer, with no done_o/err_o issued.
REQ-029 After reset gnt_o, rvalid_o, done_o, err_o, m_write_o, m_be_o, m_addr_o, m_wdata_o, rdata_o SHALL be 0; round-robin pointer SHALL favour port 0.

Configuration
REQ-030 With QSPI_ARB_TIMEOUT_EN defined, POLL SHALL count cycles; on reaching TIMEOUT_CYC SHALL skip RD_DR, go to CLR, pulse err_o[owner] with done_o[owner].
REQ-031 Without QSPI_ARB_TIMEOUT_EN, POLL SHALL wait indefinitely and err_o SHALL be constant 0.

Verification
REQ-032 req_i=01, addr0=0x100, len0=0, STA[1] set 2 cycles after WR_CCR -> writes 0x100 to 6'h04, CCR to 6'h00, one rvalid_o[0] with DR0, done_o[0].
REQ-033 req_i=11 from reset, len=1 each -> gnt_o 01 then 10; two words each; done_o[0] before done_o[1].
REQ-034 len1=7, DR0..DR7 = 0xA0..0xA7 -> eight consecutive rvalid_o[1] carrying 0xA0..0xA7, addresses 6'h08..6'h24.
REQ-035 With QSPI_ARB_TIMEOUT_EN, STA[1] never set -> after 1024 POLL cycles err_o[x] and done_o[x] together, no rvalid_o.
REQ-036 rst_i asserted in RD_DR after word 2 -> next cycle IDLE, all outputs 0, no done_o; next request granted to port 0.
